// File: rtl/phy_rcv_deframer_pkg.sv
// Shared definitions for the PHY nibble receive path: FSM states, framing bytes and
// the layout of the frame status word (also used by the transmit side).
package phy_rcv_deframer_pkg;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_PREAMBLE = 2'd1,
    ST_DATA     = 2'd2,
    ST_DROP     = 2'd3
  } rx_state_t;

  localparam logic [7:0] PRE_BYTE = 8'h55;
  localparam logic [7:0] SFD_BYTE = 8'hD5;

  localparam int CTRL_W          = 24;
  localparam int CTRL_CNT_W      = 16;
  localparam int CTRL_ODD_BIT    = 16;
  localparam int CTRL_RUNT_BIT   = 17;
  localparam int CTRL_GIANT_BIT  = 18;
  localparam int CTRL_BADPRE_BIT = 19;

  // Reserved bits [23:20] stay zero.
  function automatic logic [CTRL_W-1:0] pack_ctrl(
    input logic [CTRL_CNT_W-1:0] cnt,
    input logic                  odd,
    input logic                  runt,
    input logic                  giant,
    input logic                  bad_pre
  );
    logic [CTRL_W-1:0] ctrl;
    ctrl                   = '0;
    ctrl[CTRL_CNT_W-1:0]   = cnt;
    ctrl[CTRL_ODD_BIT]     = odd;
    ctrl[CTRL_RUNT_BIT]    = runt;
    ctrl[CTRL_GIANT_BIT]   = giant;
    ctrl[CTRL_BADPRE_BIT]  = bad_pre;
    return ctrl;
  endfunction

endpackage

// File: rtl/phy_rcv_deframer_nibble_to_byte.sv
// Pairs PHY nibbles (low nibble first) into bytes; byte_stb fires combinationally in the
// cycle the high nibble is presented so the caller can register the byte with one cycle latency.
module nibble_to_byte
  import phy_rcv_deframer_pkg::*;
(
  input  logic       clk_sys,
  input  logic       reset,
  input  logic       clr,
  input  logic       nib_valid,
  input  logic [3:0] nib_in,
  output logic [7:0] byte_out,
  output logic       byte_stb,
  output logic       half
);

  logic [3:0] low_reg;
  logic       phase_reg;

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      low_reg   <= '0;
      phase_reg <= 1'b0;
    end else if (clr) begin
      low_reg   <= '0;
      phase_reg <= 1'b0;
    end else if (nib_valid) begin
      if (!phase_reg) begin
        low_reg <= nib_in;
      end
      phase_reg <= ~phase_reg;
    end
  end

  for (genvar gi = 0; gi < 4; gi++) begin : g_assemble
    assign byte_out[gi]     = low_reg[gi];
    assign byte_out[gi + 4] = nib_in[gi];
  end

  assign byte_stb = nib_valid & phase_reg & ~clr;
  assign half     = phase_reg;

endmodule

// File: rtl/phy_rcv_deframer.sv
// Receive deframer: strips 0x55 preamble and 0xD5 SFD from a nibble-wide PHY stream,
// emits payload bytes and a status word with length and error flags at frame end.
module phy_rcv_deframer
  import phy_rcv_deframer_pkg::*;
#(
  parameter int MIN_LEN = 64,
  parameter int MAX_LEN = 2048,
  parameter int MAX_PRE = 15
) (
  input  logic        clk_sys,
  input  logic        reset,
  input  logic [3:0]  phy_data_in,
  input  logic        phy_rx_dv,
  output logic [7:0]  r_data_out,
  output logic        r_data_valid,
  output logic        r_sof,
  output logic        r_eof,
  output logic [23:0] r_ctrl_out
);

  rx_state_t   state_reg, state_next;
  logic [15:0] pre_cnt_reg, pre_cnt_next;
  logic [15:0] byte_cnt_reg, byte_cnt_next;
  logic        bad_pre_reg, bad_pre_next;
  logic        giant_reg, giant_next;
  logic [7:0]  data_reg, data_next;
  logic        valid_reg, valid_next;
  logic        sof_reg, sof_next;
  logic        eof_reg, eof_next;
  logic [23:0] ctrl_reg, ctrl_next;

  logic [7:0]  asm_byte;
  logic        asm_stb;
  logic        asm_half;
  logic        asm_clr;
  logic        asm_valid;

  // Assembly stops while dropping and restarts clean on every new frame.
  assign asm_clr   = ~phy_rx_dv | (state_reg == ST_DROP);
  assign asm_valid = phy_rx_dv & (state_reg != ST_DROP);

  nibble_to_byte u_nibble_to_byte (
    .clk_sys   (clk_sys),
    .reset     (reset),
    .clr       (asm_clr),
    .nib_valid (asm_valid),
    .nib_in    (phy_data_in),
    .byte_out  (asm_byte),
    .byte_stb  (asm_stb),
    .half      (asm_half)
  );

  always_ff @(posedge clk_sys or posedge reset) begin
    if (reset) begin
      state_reg    <= ST_IDLE;
      pre_cnt_reg  <= '0;
      byte_cnt_reg <= '0;
      bad_pre_reg  <= 1'b0;
      giant_reg    <= 1'b0;
      data_reg     <= '0;
      valid_reg    <= 1'b0;
      sof_reg      <= 1'b0;
      eof_reg      <= 1'b0;
      ctrl_reg     <= '0;
    end else begin
      state_reg    <= state_next;
      pre_cnt_reg  <= pre_cnt_next;
      byte_cnt_reg <= byte_cnt_next;
      bad_pre_reg  <= bad_pre_next;
      giant_reg    <= giant_next;
      data_reg     <= data_next;
      valid_reg    <= valid_next;
      sof_reg      <= sof_next;
      eof_reg      <= eof_next;
      ctrl_reg     <= ctrl_next;
    end
  end

  always_comb begin
    state_next    = state_reg;
    pre_cnt_next  = pre_cnt_reg;
    byte_cnt_next = byte_cnt_reg;
    bad_pre_next  = bad_pre_reg;
    giant_next    = giant_reg;
    data_next     = data_reg;
    valid_next    = 1'b0;
    sof_next      = 1'b0;
    eof_next      = 1'b0;
    ctrl_next     = ctrl_reg;

    unique case (state_reg)
      ST_IDLE: begin
        pre_cnt_next  = '0;
        byte_cnt_next = '0;
        bad_pre_next  = 1'b0;
        giant_next    = 1'b0;
        if (phy_rx_dv) begin
          state_next = ST_PREAMBLE;
        end
      end

      ST_PREAMBLE: begin
        if (!phy_rx_dv) begin
          state_next = ST_IDLE;
          eof_next   = 1'b1;
          ctrl_next  = pack_ctrl(16'd0, asm_half, 1'b0, 1'b0, 1'b1);
        end else if (asm_stb) begin
          if (asm_byte == PRE_BYTE) begin
            // The counter would pass MAX_PRE with this byte: too long a preamble.
            if (pre_cnt_reg >= 16'(MAX_PRE)) begin
              state_next   = ST_DROP;
              bad_pre_next = 1'b1;
            end else begin
              pre_cnt_next = pre_cnt_reg + 16'd1;
            end
          end else if (asm_byte == SFD_BYTE) begin
            state_next    = ST_DATA;
            byte_cnt_next = '0;
          end else begin
            state_next   = ST_DROP;
            bad_pre_next = 1'b1;
          end
        end
      end

      ST_DATA: begin
        if (!phy_rx_dv) begin
          state_next = ST_IDLE;
          eof_next   = 1'b1;
          ctrl_next  = pack_ctrl(byte_cnt_reg, asm_half,
                                 byte_cnt_reg < 16'(MIN_LEN), 1'b0, 1'b0);
        end else if (asm_stb) begin
          if (byte_cnt_reg == 16'(MAX_LEN)) begin
            state_next = ST_DROP;
            giant_next = 1'b1;
          end else begin
            data_next     = asm_byte;
            valid_next    = 1'b1;
            sof_next      = (byte_cnt_reg == 16'd0);
            byte_cnt_next = (byte_cnt_reg == 16'hFFFF) ? byte_cnt_reg : byte_cnt_reg + 16'd1;
          end
        end
      end

      ST_DROP: begin
        if (!phy_rx_dv) begin
          state_next = ST_IDLE;
          eof_next   = 1'b1;
          ctrl_next  = pack_ctrl(byte_cnt_reg, 1'b0, 1'b0, giant_reg, bad_pre_reg);
        end
      end

      default: state_next = ST_IDLE;
    endcase
  end

  assign r_data_out   = data_reg;
  assign r_data_valid = valid_reg;
  assign r_sof        = sof_reg;
  assign r_eof        = eof_reg;
  assign r_ctrl_out   = ctrl_reg;

endmodule

// File: tb/tb_phy_rcv_deframer.sv
// Bench for phy_rcv_deframer: frame-level reference model predicts every output strobe and
// its cycle; a per-cycle compare process checks the DUT against those predictions.
module tb_phy_rcv_deframer;

  localparam int MIN_LEN = 64;
  localparam int MAX_LEN = 2048;
  localparam int MAX_PRE = 15;

  logic        clk_sys;
  logic        reset;
  logic [3:0]  phy_data_in;
  logic        phy_rx_dv;
  logic [7:0]  r_data_out;
  logic        r_data_valid;
  logic        r_sof;
  logic        r_eof;
  logic [23:0] r_ctrl_out;

  phy_rcv_deframer #(.MIN_LEN(MIN_LEN), .MAX_LEN(MAX_LEN), .MAX_PRE(MAX_PRE)) dut (
    .clk_sys      (clk_sys),
    .reset        (reset),
    .phy_data_in  (phy_data_in),
    .phy_rx_dv    (phy_rx_dv),
    .r_data_out   (r_data_out),
    .r_data_valid (r_data_valid),
    .r_sof        (r_sof),
    .r_eof        (r_eof),
    .r_ctrl_out   (r_ctrl_out)
  );

  initial clk_sys = 1'b0;
  always #5 clk_sys = ~clk_sys;

  typedef struct { int cyc; logic [7:0] d; logic sof; } exp_byte_t;
  typedef struct { int cyc; logic [23:0] ctrl; } exp_eof_t;

  exp_byte_t  bq[$];
  exp_eof_t   eq[$];
  logic [3:0] fq[$];

  int          cyc = 0;
  int          n_cmp = 0;
  int          n_bad = 0;
  int          dv_seen = 0;
  int          eof_seen = 0;
  logic [23:0] last_ctrl = 24'h0;
  logic [23:0] last_ctrl_seen = 24'h0;

  always @(posedge clk_sys) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Per-cycle compare against the model's scheduled expectations.
  always begin
    @(posedge clk_sys);
    #1;
    if (reset) begin
      chk("reset_outputs", {r_data_out, r_data_valid, r_sof, r_eof, r_ctrl_out}, 32'h0);
      last_ctrl = 24'h0;
    end else begin
      logic exp_v, exp_e;
      exp_v = (bq.size() > 0) && (bq[0].cyc == cyc);
      exp_e = (eq.size() > 0) && (eq[0].cyc == cyc);
      chk("data_valid", r_data_valid, exp_v);
      if (exp_v) begin
        if (r_data_valid) begin
          chk("data_byte", r_data_out, bq[0].d);
          chk("sof", r_sof, bq[0].sof);
        end
        void'(bq.pop_front());
      end else begin
        chk("sof_idle", r_sof, 1'b0);
      end
      chk("eof", r_eof, exp_e);
      if (exp_e) begin
        last_ctrl = eq[0].ctrl;
        void'(eq.pop_front());
      end
      chk("ctrl_out", r_ctrl_out, last_ctrl);
      chk("valid_eof_excl", r_data_valid & r_eof, 1'b0);
      if (r_data_valid) dv_seen++;
      if (r_eof) begin
        eof_seen++;
        last_ctrl_seen = r_ctrl_out;
      end
    end
  end

  task automatic push_byte(input logic [7:0] b);
    fq.push_back(b[3:0]);
    fq.push_back(b[7:4]);
  endtask

  task automatic push_hdr(input int npre);
    for (int i = 0; i < npre; i++) push_byte(8'h55);
    push_byte(8'hD5);
  endtask

  // Frame-level model: parse the whole nibble list into bytes, apply the preamble/SFD/length
  // rules, and schedule each emitted byte and the end-of-frame status at absolute cycles.
  task automatic model_frame(input int s, output logic [23:0] mctrl);
    int n, nb, p, d, m, emit;
    bit bad;
    logic [7:0] b;
    n = fq.size(); nb = n / 2; p = 0; d = -1; bad = 0;
    for (int i = 0; i < nb; i++) begin
      b = {fq[2*i+1], fq[2*i]};
      if (b == 8'h55) begin
        p++;
        if (p > MAX_PRE) begin bad = 1; break; end
      end else if (b == 8'hD5) begin
        d = i + 1; break;
      end else begin
        bad = 1; break;
      end
    end
    if (d < 0) begin
      mctrl = 24'h080000;
      if (!bad && (n % 2 == 1)) mctrl = mctrl | 24'h010000;
    end else begin
      m = nb - d;
      emit = (m > MAX_LEN) ? MAX_LEN : m;
      for (int j = 0; j < emit; j++) begin
        exp_byte_t e;
        e.cyc = s + 2 * (d + j) + 1;
        e.d   = {fq[2*(d+j)+1], fq[2*(d+j)]};
        e.sof = (j == 0);
        bq.push_back(e);
      end
      if (m > MAX_LEN) mctrl = 24'h040000 | 24'(MAX_LEN);
      else mctrl = 24'(m) | ((n % 2 == 1) ? 24'h010000 : 24'h0) | ((m < MIN_LEN) ? 24'h020000 : 24'h0);
    end
    begin
      exp_eof_t ee;
      ee.cyc  = s + n;
      ee.ctrl = mctrl;
      eq.push_back(ee);
    end
  endtask

  // Called at a negedge. abort_at >= 0 pulses reset after that many nibbles.
  task automatic drive_frame(input int gap, input int abort_at, output logic [23:0] mctrl);
    int s, r;
    s = cyc + 1;
    model_frame(s, mctrl);
    for (int k = 0; k < fq.size(); k++) begin
      if (k == abort_at) break;
      phy_rx_dv = 1'b1;
      phy_data_in = fq[k];
      @(negedge clk_sys);
    end
    phy_rx_dv = 1'b0;
    phy_data_in = 4'h0;
    if (abort_at >= 0) begin
      reset = 1'b1;
      r = cyc;
      while (bq.size() > 0 && bq[bq.size()-1].cyc > r) void'(bq.pop_back());
      while (eq.size() > 0 && eq[eq.size()-1].cyc > r) void'(eq.pop_back());
      repeat (3) @(negedge clk_sys);
      reset = 1'b0;
    end
    repeat (gap) @(negedge clk_sys);
    fq.delete();
  endtask

  initial begin
    logic [23:0] mc;
    int base, ebase, npre, plen, kind;
    reset = 1'b1;
    phy_rx_dv = 1'b0;
    phy_data_in = 4'h0;
    repeat (3) @(negedge clk_sys);
    reset = 1'b0;
    @(negedge clk_sys);

    // 7x preamble + SFD, 64 incrementing bytes
    push_hdr(7);
    for (int i = 0; i < 64; i++) push_byte(8'(i));
    base = dv_seen;
    drive_frame(2, -1, mc);
    chk("model_64", mc, 24'h000040);
    chk("frame64_bytes", dv_seen - base, 64);
    chk("frame64_ctrl", last_ctrl_seen, 24'h000040);

    // 512-byte patterned frame
    push_hdr(7);
    for (int i = 0; i < 512; i++) push_byte((i < 4 || i >= 508) ? 8'h33 : 8'hFF);
    base = dv_seen;
    drive_frame(2, -1, mc);
    chk("frame512_bytes", dv_seen - base, 512);
    chk("frame512_ctrl", last_ctrl_seen, 24'h000200);

    // runt
    push_hdr(7);
    for (int i = 0; i < 10; i++) push_byte(8'(8'hA0 + i));
    drive_frame(1, -1, mc);
    chk("model_runt", mc, 24'h02000A);
    chk("runt_ctrl", last_ctrl_seen, 24'h02000A);

    // bad preamble
    push_byte(8'h55); push_byte(8'h57); push_byte(8'hD5); push_byte(8'h12);
    base = dv_seen;
    drive_frame(2, -1, mc);
    chk("badpre_bytes", dv_seen - base, 0);
    chk("badpre_ctrl", last_ctrl_seen, 24'h080000);

    // odd nibble
    push_hdr(7);
    for (int i = 0; i < 70; i++) push_byte(8'(i * 3));
    fq.push_back(4'h9);
    drive_frame(1, -1, mc);
    chk("odd_ctrl", last_ctrl_seen, 24'h010046);

    // giant
    push_hdr(7);
    for (int i = 0; i < MAX_LEN + 5; i++) push_byte(8'(i ^ 8'h5A));
    base = dv_seen;
    drive_frame(2, -1, mc);
    chk("model_giant", mc, 24'h040000 | 24'(MAX_LEN));
    chk("giant_bytes", dv_seen - base, MAX_LEN);
    chk("giant_bit", last_ctrl_seen[18], 1'b1);

    // back-to-back frames, then reset mid-frame
    ebase = eof_seen;
    for (int f = 0; f < 2; f++) begin
      push_hdr(7);
      for (int i = 0; i < 64; i++) push_byte(8'(i + f * 64));
      drive_frame(1, -1, mc);
    end
    chk("b2b_eofs", eof_seen - ebase, 2);
    push_hdr(7);
    for (int i = 0; i < 64; i++) push_byte(8'(i));
    drive_frame(3, 40, mc);
    chk("reset_no_eof", eof_seen - ebase, 2);

    // randomized frames
    for (int f = 0; f < 30; f++) begin
      kind = $urandom_range(0, 9);
      npre = (kind == 0) ? $urandom_range(MAX_PRE + 1, MAX_PRE + 3) : $urandom_range(1, MAX_PRE);
      for (int i = 0; i < npre; i++) push_byte(8'h55);
      if (kind == 1) push_byte(8'($urandom_range(0, 255)));
      else if (kind != 2) push_byte(8'hD5);
      if (kind != 2) begin
        plen = $urandom_range(0, 90);
        for (int i = 0; i < plen; i++) push_byte(8'($urandom_range(0, 255)));
      end
      if ($urandom_range(0, 2) == 0) fq.push_back(4'($urandom_range(0, 15)));
      drive_frame($urandom_range(1, 3), -1, mc);
    end

    repeat (4) @(negedge clk_sys);
    chk("bytes_all_seen", bq.size(), 0);
    chk("eofs_all_seen", eq.size(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/phy_rcv_deframer.md
PHY_RCV_DEFRAMER -- requirements
Module: phy_rcv_deframer

Interface
REQ-001 Parameter MIN_LEN, default 64, minimum legal payload byte count; shorter frames are flagged runt.
REQ-002 Parameter MAX_LEN, default 2048, maximum legal payload byte count; longer frames are flagged giant.
REQ-003 Parameter MAX_PRE, default 15, maximum number of preamble bytes accepted before SFD.
REQ-004 clk_sys  input  1  single block clock; all state changes on its rising edge.
REQ-005 reset  input  1  asynchronous, active-high reset.
REQ-006 phy_data_in  input  4  PHY receive nibble, sampled only when phy_rx_dv=1.
REQ-007 phy_rx_dv  input  1  PHY receive data valid; one nibble per clk_sys cycle while high.
REQ-008 r_data_out  output  8  reassembled payload byte.
REQ-009 r_data_valid  output  1  one-cycle strobe qualifying r_data_out.
REQ-010 r_sof  output  1  asserted together with r_data_valid on the first payload byte only.
REQ-011 r_eof  output  1  one-cycle strobe marking frame end; qualifies r_ctrl_out.
REQ-012 r_ctrl_out  output  24  frame status block: [15:0] byte count, [16] odd-nibble, [17] runt, [18] giant, [19] bad preamble, [23:20] zero.

Function
REQ-013 Nibble order SHALL be low nibble first: byte = {second nibble, first nibble}.
REQ-014 FSM states: IDLE, PREAMBLE, DATA, DROP.
REQ-015 IDLE: phy_rx_dv=1 -> PREAMBLE, first sampled nibble taken as low nibble of first byte.
REQ-016 PREAMBLE: each completed byte 0x55 increments preamble counter; byte 0xD5 -> DATA; any other byte, or counter exceeding MAX_PRE -> DROP.
REQ-017 DATA: each completed byte drives r_data_out/r_data_valid in the cycle after its high nibble is sampled (latency 1 cycle); preamble and SFD bytes are never emitted.
REQ-018 Byte counter is 16 bits, cleared on entering DATA, incremented per emitted byte, saturating at 16'hFFFF.
REQ-019 Byte count reaching MAX_LEN+1 -> DROP with giant set; the (MAX_LEN+1)th byte and later bytes are not emitted.
REQ-020 DROP: ignore all nibbles until phy_rx_dv=0.
REQ-021 phy_rx_dv sampled 0 in PREAMBLE, DATA or DROP -> IDLE and r_eof pulses for exactly one cycle in the following cycle, with r_ctrl_out holding status.
REQ-022 odd-nibble: phy_rx_dv falls with a half-assembled byte; the partial byte is discarded.
REQ-023 runt: frame reached DATA and final count < MIN_LEN; bad preamble: frame ended in PREAMBLE or entered DROP from PREAMBLE, count reported 0.
REQ-024 r_ctrl_out SHALL hold its value from r_eof until the next r_eof.
REQ-025 phy_rx_dv reasserted in the cycle immediately after it falls SHALL start a new frame (IDLE entered and left on consecutive edges) without losing the r_eof pulse.
REQ-026 r_data_valid and r_eof never assert in the same cycle.

Reset
REQ-027 reset=1 forces IDLE asynchronously; r_data_out=8'h00, r_data_valid=0, r_sof=0, r_eof=0, r_ctrl_out=24'h0, all counters and nibble latch zero.
REQ-028 Reset asserted mid-frame discards the frame with no r_eof; after release, a frame still in progress (phy_rx_dv=1) is treated as starting at the first sampled nibble.

Structure
REQ-029 Shared package holds FSM state encoding, SFD (8'hD5) and preamble (8'h55) constants, and r_ctrl_out bit-position constants shared with the transmit path.
REQ-030 One sub-module, nibble_to_byte (nibble latch, phase bit, byte strobe), instantiated once; FSM and counters live in phy_rcv_deframer.

Verification
REQ-031 7x 0x55, 0xD5, 64 bytes 0x00..0x3F (nibbles low-first) -> 64 r_data_valid strobes in order, r_sof on 0x00, r_eof with r_ctrl_out=24'h000040.
REQ-032 512-byte frame of 4x 0x33, 504x 0xFF, 4x 0x33 -> 512 bytes, r_eof with r_ctrl_out=24'h000200.
REQ-033 Valid preamble/SFD, 10 bytes -> 10 bytes emitted, r_ctrl_out=24'h02000A (runt).
REQ-034 Preamble 0x55, 0x57 -> no r_data_valid, r_eof with r_ctrl_out=24'h080000.
REQ-035 Valid frame of 70 bytes plus one extra nibble -> 70 bytes, r_ctrl_out=24'h010046; MAX_LEN+5 bytes -> MAX_LEN bytes emitted, bit [18] set.
REQ-036 Two back-to-back 64-byte frames separated by one phy_rx_dv=0 cycle, then reset pulse in the middle of a third frame -> two r_eof pulses, third frame no r_eof, all outputs zero during reset.
